// File: rtl/rmii_rx_to_axis.sv
`timescale 1ns/1ps
// RMII receiver: strips preamble/SFD, assembles LSB-first dibits into bytes and
// streams them as a back-pressure-free AXI-Stream, counting good and errored frames.
module rmii_rx_to_axis #(
  parameter int MIN_PREAMBLE = 4
) (
  input  logic        clk,
  input  logic        sresetn,
  input  logic [1:0]  rxd,
  input  logic        crs_dv,
  input  logic        rx_er,
  output logic        rx_axis_tvalid,
  output logic [7:0]  rx_axis_tdata,
  output logic        rx_axis_tlast,
  output logic        rx_axis_tuser,
  output logic [15:0] frame_count,
  output logic [15:0] error_count
);
  localparam int PW = (MIN_PREAMBLE < 1) ? 1 : $clog2(MIN_PREAMBLE + 1);
  localparam logic [PW-1:0] PRE_MIN = PW'(MIN_PREAMBLE);

  typedef enum logic [1:0] {WAIT_IDLE, IDLE, PREAMBLE, DATA} state_t;

  logic [1:0]    rxd_s1_q, rxd_s2_q;
  logic          crs_s1_q, crs_s2_q, er_s1_q, er_s2_q;
  state_t        state_q, state_d;
  logic [PW-1:0] pre_cnt_q, pre_cnt_d;
  logic [1:0]    pos_q, pos_d;
  logic [5:0]    sr_q, sr_d;
  logic [7:0]    hold_q, hold_d;
  logic          hold_full_q, hold_full_d;
  logic          err_q, err_d;
  logic          pend_q, pend_d, pend_user_q, pend_user_d;
  logic          tvalid_q, tvalid_d, tlast_q, tlast_d, tuser_q, tuser_d;
  logic [7:0]    tdata_q, tdata_d;
  logic [15:0]   frame_count_q, frame_count_d, error_count_q, error_count_d;
  logic          commit, eof, emit, emit_last, emit_user, count_err;

  // The dibit in stage 2 is kept if carrier was seen in its own cycle or the next.
  assign commit = crs_s1_q | crs_s2_q;
  assign eof    = !commit;

  always_comb begin
    state_d       = state_q;
    pre_cnt_d     = pre_cnt_q;
    pos_d         = pos_q;
    sr_d          = sr_q;
    hold_d        = hold_q;
    hold_full_d   = hold_full_q;
    err_d         = err_q;
    pend_d        = pend_q;
    pend_user_d   = pend_user_q;
    tvalid_d      = 1'b0;
    tlast_d       = 1'b0;
    tuser_d       = 1'b0;
    tdata_d       = tdata_q;
    frame_count_d = frame_count_q;
    error_count_d = error_count_q;
    emit          = 1'b0;
    emit_last     = 1'b0;
    emit_user     = 1'b0;
    count_err     = 1'b0;

    // A tlast beat deferred one cycle so tvalid never asserts back-to-back.
    if (pend_q) begin
      emit        = 1'b1;
      emit_last   = 1'b1;
      emit_user   = pend_user_q;
      pend_d      = 1'b0;
      hold_full_d = 1'b0;
    end

    case (state_q)
      WAIT_IDLE: if (eof) state_d = IDLE;
      IDLE: begin
        if (commit && rxd_s2_q == 2'b01) begin
          state_d   = PREAMBLE;
          pre_cnt_d = PW'(1);
        end
      end
      PREAMBLE: begin
        if (eof || er_s2_q) begin
          state_d = WAIT_IDLE;
        end else if (rxd_s2_q == 2'b01) begin
          if (pre_cnt_q < PRE_MIN) pre_cnt_d = pre_cnt_q + 1'b1;
        end else if (rxd_s2_q == 2'b11 && pre_cnt_q >= PRE_MIN) begin
          state_d = DATA;
          pos_d   = 2'd0;
          err_d   = 1'b0;
        end else begin
          state_d = WAIT_IDLE;
        end
      end
      DATA: begin
        if (eof) begin
          state_d = IDLE;
          if (hold_full_q) begin
            if (tvalid_q) begin
              pend_d      = 1'b1;
              pend_user_d = err_q | (pos_q != 2'd0);
            end else begin
              emit        = 1'b1;
              emit_last   = 1'b1;
              emit_user   = err_q | (pos_q != 2'd0);
              hold_full_d = 1'b0;
            end
          end else begin
            count_err = 1'b1;
          end
        end else begin
          if (er_s2_q && crs_s2_q) err_d = 1'b1;
          case (pos_q)
            2'd0: sr_d[1:0] = rxd_s2_q;
            2'd1: sr_d[3:2] = rxd_s2_q;
            2'd2: sr_d[5:4] = rxd_s2_q;
            default: begin
              emit        = hold_full_q;
              hold_d      = {rxd_s2_q, sr_q};
              hold_full_d = 1'b1;
            end
          endcase
          pos_d = pos_q + 2'd1;
        end
      end
      default: state_d = WAIT_IDLE;
    endcase

    if (emit) begin
      tvalid_d = 1'b1;
      tdata_d  = hold_q;
      tlast_d  = emit_last;
      tuser_d  = emit_user;
      if (emit_last) begin
        if (emit_user) count_err = 1'b1;
        else if (frame_count_q != 16'hFFFF) frame_count_d = frame_count_q + 16'd1;
      end
    end
    if (count_err && error_count_q != 16'hFFFF) error_count_d = error_count_q + 16'd1;
  end

  always_ff @(posedge clk) begin
    if (!sresetn) begin
      // Carrier history resets high so a frame in progress must first go idle.
      rxd_s1_q      <= 2'b00;
      rxd_s2_q      <= 2'b00;
      crs_s1_q      <= 1'b1;
      crs_s2_q      <= 1'b1;
      er_s1_q       <= 1'b0;
      er_s2_q       <= 1'b0;
      state_q       <= WAIT_IDLE;
      pre_cnt_q     <= '0;
      pos_q         <= 2'd0;
      sr_q          <= 6'd0;
      hold_q        <= 8'd0;
      hold_full_q   <= 1'b0;
      err_q         <= 1'b0;
      pend_q        <= 1'b0;
      pend_user_q   <= 1'b0;
      tvalid_q      <= 1'b0;
      tlast_q       <= 1'b0;
      tuser_q       <= 1'b0;
      tdata_q       <= 8'd0;
      frame_count_q <= 16'd0;
      error_count_q <= 16'd0;
    end else begin
      rxd_s1_q      <= rxd;
      rxd_s2_q      <= rxd_s1_q;
      crs_s1_q      <= crs_dv;
      crs_s2_q      <= crs_s1_q;
      er_s1_q       <= rx_er;
      er_s2_q       <= er_s1_q;
      state_q       <= state_d;
      pre_cnt_q     <= pre_cnt_d;
      pos_q         <= pos_d;
      sr_q          <= sr_d;
      hold_q        <= hold_d;
      hold_full_q   <= hold_full_d;
      err_q         <= err_d;
      pend_q        <= pend_d;
      pend_user_q   <= pend_user_d;
      tvalid_q      <= tvalid_d;
      tlast_q       <= tlast_d;
      tuser_q       <= tuser_d;
      tdata_q       <= tdata_d;
      frame_count_q <= frame_count_d;
      error_count_q <= error_count_d;
    end
  end

  assign rx_axis_tvalid = tvalid_q;
  assign rx_axis_tdata  = tdata_q;
  assign rx_axis_tlast  = tlast_q;
  assign rx_axis_tuser  = tuser_q;
  assign frame_count    = frame_count_q;
  assign error_count    = error_count_q;
endmodule
